// File: rtl/ir_tx_if.sv
// rtl/ir_tx_if.sv - Request/status bundle between frame source and the NEC IR transmitter.
interface ir_tx_if;
  logic        i_start;
  logic [31:0] i_data;
  logic        i_repeat;
  logic        o_ir_tx;
  logic        o_ir_env;
  logic        o_busy;
  logic        o_done;

  modport master (
    output i_start, i_data, i_repeat,
    input  o_ir_tx, o_ir_env, o_busy, o_done
  );

  modport slave (
    input  i_start, i_data, i_repeat,
    output o_ir_tx, o_ir_env, o_busy, o_done
  );
endinterface

// File: rtl/ir_tx.sv
// rtl/ir_tx.sv - NEC infrared transmitter: leader, 32 pulse-distance bits, stop mark, gap.
// Repeat-code states are built only when IR_TX_REPEAT_EN is defined.
module ir_tx #(
  parameter int TICK_DIV     = 50,
  parameter int CARRIER_DIV  = 1316,
  parameter int T_LEAD_MARK  = 9000,
  parameter int T_LEAD_SPACE = 4500,
  parameter int T_BIT_MARK   = 560,
  parameter int T_ZERO_SPACE = 560,
  parameter int T_ONE_SPACE  = 1690,
  parameter int T_STOP_MARK  = 560,
  parameter int T_FRAME      = 108000,
  parameter int T_REP_SPACE  = 2250
) (
  input  logic   clk,
  input  logic   rst_n,
  ir_tx_if.slave bus
);

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int CW = $clog2(CARRIER_DIV + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEAD_MARK,
    S_LEAD_SPACE,
    S_BIT_MARK,
    S_BIT_SPACE,
    S_STOP_MARK,
`ifdef IR_TX_REPEAT_EN
    S_REP_MARK,
    S_REP_SPACE,
    S_REP_STOP,
    S_REP_GAP,
`endif
    S_GAP
  } state_t;

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic [16:0]   dur;
  logic [16:0]   frame_cnt;
  logic [CW-1:0] car_cnt;
  logic [31:0]   shreg;
  logic [5:0]    bit_cnt;
  logic          env;
  logic          ir_tx;
  logic          busy;
  logic          done;

  logic          tick;
  logic          dur_end;
  logic          frame_end;
  logic [CW-1:0] car_nxt;
  logic          car_hi_nxt;

  assign tick       = (tick_cnt == TW'(TICK_DIV - 1));
  assign dur_end    = tick && (dur == 17'd1);
  assign frame_end  = tick && (frame_cnt >= 17'(T_FRAME - 1));
  assign car_nxt    = (car_cnt == CW'(CARRIER_DIV - 1)) ? '0 : car_cnt + 1'b1;
  assign car_hi_nxt = (car_nxt < CW'(CARRIER_DIV / 2));

`ifndef IR_TX_REPEAT_EN
  wire unused_repeat = bus.i_repeat ^ (T_REP_SPACE == 0);
`endif

  // Defaults run the counters and carrier; state transitions below override them.
  // ir_tx is computed from next-cycle values so it stays a pure register output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      tick_cnt  <= '0;
      dur       <= '0;
      frame_cnt <= '0;
      car_cnt   <= '0;
      shreg     <= '0;
      bit_cnt   <= '0;
      env       <= 1'b0;
      ir_tx     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done     <= 1'b0;
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (tick && dur != 17'd0) dur <= dur - 17'd1;
      if (tick && frame_cnt != 17'(T_FRAME)) frame_cnt <= frame_cnt + 17'd1;
      car_cnt  <= car_nxt;
      ir_tx    <= env & car_hi_nxt;

      case (state)
        S_IDLE: begin
          if (bus.i_start) begin
            state     <= S_LEAD_MARK;
            dur       <= 17'(T_LEAD_MARK);
            shreg     <= bus.i_data;
            bit_cnt   <= '0;
            busy      <= 1'b1;
            tick_cnt  <= '0;
            frame_cnt <= '0;
            env       <= 1'b1;
            ir_tx     <= 1'b1;
            car_cnt   <= '0;
          end
        end
        S_LEAD_MARK: if (dur_end) begin
          state <= S_LEAD_SPACE;
          dur   <= 17'(T_LEAD_SPACE);
          env   <= 1'b0;
          ir_tx <= 1'b0;
        end
        S_LEAD_SPACE: if (dur_end) begin
          state   <= S_BIT_MARK;
          dur     <= 17'(T_BIT_MARK);
          env     <= 1'b1;
          ir_tx   <= 1'b1;
          car_cnt <= '0;
        end
        S_BIT_MARK: if (dur_end) begin
          state <= S_BIT_SPACE;
          dur   <= shreg[31] ? 17'(T_ONE_SPACE) : 17'(T_ZERO_SPACE);
          env   <= 1'b0;
          ir_tx <= 1'b0;
        end
        S_BIT_SPACE: if (dur_end) begin
          shreg   <= {shreg[30:0], 1'b0};
          bit_cnt <= bit_cnt + 6'd1;
          state   <= (bit_cnt == 6'd31) ? S_STOP_MARK : S_BIT_MARK;
          dur     <= (bit_cnt == 6'd31) ? 17'(T_STOP_MARK) : 17'(T_BIT_MARK);
          env     <= 1'b1;
          ir_tx   <= 1'b1;
          car_cnt <= '0;
        end
        S_STOP_MARK: if (dur_end) begin
          state <= S_GAP;
          dur   <= '0;
          env   <= 1'b0;
          ir_tx <= 1'b0;
        end
`ifdef IR_TX_REPEAT_EN
        S_REP_MARK: if (dur_end) begin
          state <= S_REP_SPACE;
          dur   <= 17'(T_REP_SPACE);
          env   <= 1'b0;
          ir_tx <= 1'b0;
        end
        S_REP_SPACE: if (dur_end) begin
          state   <= S_REP_STOP;
          dur     <= 17'(T_STOP_MARK);
          env     <= 1'b1;
          ir_tx   <= 1'b1;
          car_cnt <= '0;
        end
        S_REP_STOP: if (dur_end) begin
          state <= S_REP_GAP;
          dur   <= '0;
          env   <= 1'b0;
          ir_tx <= 1'b0;
        end
        S_GAP, S_REP_GAP: if (frame_end) begin
          done <= 1'b1;
          if (bus.i_repeat) begin
            state     <= S_REP_MARK;
            dur       <= 17'(T_LEAD_MARK);
            frame_cnt <= '0;
            env       <= 1'b1;
            ir_tx     <= 1'b1;
            car_cnt   <= '0;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
`else
        S_GAP: if (frame_end) begin
          done  <= 1'b1;
          state <= S_IDLE;
          busy  <= 1'b0;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_ir_tx  = ir_tx;
  assign bus.o_ir_env = env;
  assign bus.o_busy   = busy;
  assign bus.o_done   = done;

endmodule

// File: tb/tb_ir_tx.sv
// tb/tb_ir_tx.sv - Directed bench for ir_tx with shortened timing constants.
module tb_ir_tx;

  localparam int TD = 2;
  localparam int CD = 10;
  localparam int LM = 90;
  localparam int LS = 45;
  localparam int BM = 6;
  localparam int ZS = 6;
  localparam int OS = 17;
  localparam int ST = 6;
  localparam int FR = 1080;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ir_tx_if bus ();

  ir_tx #(
    .TICK_DIV    (TD),
    .CARRIER_DIV (CD),
    .T_LEAD_MARK (LM),
    .T_LEAD_SPACE(LS),
    .T_BIT_MARK  (BM),
    .T_ZERO_SPACE(ZS),
    .T_ONE_SPACE (OS),
    .T_STOP_MARK (ST),
    .T_FRAME     (FR)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int   compared   = 0;
  int   mismatched = 0;

  int   cyc        = 0;
  int   edges[$];
  logic prev_env   = 1'b0;
  logic prev_busy  = 1'b0;
  int   busy_rise  = -1;
  int   done_cyc   = -1;
  int   phase      = 0;
  int   car_err    = 0;
  int   car_n      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Envelope edge log, busy/done timestamps and an independent carrier model.
  always @(negedge clk) begin : mon
    automatic int   ph;
    automatic logic exp_tx;
    if (bus.o_ir_env !== prev_env) edges.push_back(cyc);
    if (bus.o_busy === 1'b1 && prev_busy !== 1'b1) busy_rise <= cyc;
    if (bus.o_done === 1'b1) done_cyc <= cyc;
    ph     = (prev_env === 1'b1) ? phase + 1 : 0;
    exp_tx = (bus.o_ir_env === 1'b1) && ((ph % CD) < CD / 2);
    if (bus.o_ir_tx !== exp_tx) car_err <= car_err + 1;
    car_n     <= car_n + 1;
    phase     <= (bus.o_ir_env === 1'b1) ? ph : 0;
    prev_env  <= bus.o_ir_env;
    prev_busy <= bus.o_busy;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_frame(input logic [31:0] d);
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_data  = d;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_data  = $urandom;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (bus.o_done !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, bus.o_done, 1);
    chk({tag, "_busy_at_done"}, bus.o_busy, 0);
    #1;
    chk({tag, "_done_time"}, done_cyc - busy_rise, FR * TD);
  endtask

  task automatic check_frame(input logic [31:0] d, input string tag);
    int exp_seg[$];
    exp_seg.push_back(LM * TD);
    exp_seg.push_back(LS * TD);
    for (int k = 0; k < 32; k++) begin
      exp_seg.push_back(BM * TD);
      exp_seg.push_back((d[31-k] ? OS : ZS) * TD);
    end
    exp_seg.push_back(ST * TD);
    chk({tag, "_edges"}, edges.size(), 68);
    if (edges.size() == 68) begin
      for (int i = 0; i < 67; i++)
        chk($sformatf("%s_seg%0d", tag, i), edges[i+1] - edges[i], exp_seg[i]);
    end
  endtask

  initial begin
    bus.i_start  = 1'b0;
    bus.i_data   = '0;
    bus.i_repeat = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ir_tx",  bus.o_ir_tx,  0);
    chk("rst_ir_env", bus.o_ir_env, 0);
    chk("rst_busy",   bus.o_busy,   0);
    chk("rst_done",   bus.o_done,   0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame with start latency.
    edges.delete();
    start_frame(32'h00FF_A25D);
    chk("lat_busy", bus.o_busy,   1);
    chk("lat_env",  bus.o_ir_env, 1);
    chk("lat_tx",   bus.o_ir_tx,  1);
    wait_done("basic");
    check_frame(32'h00FF_A25D, "basic");
    if (edges.size() > 0) chk("basic_env_len", edges[edges.size()-1] - edges[0], 1402);

    // All-zero word with an ignored mid-frame start.
    edges.delete();
    start_frame(32'h0000_0000);
    repeat (300) @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_data  = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.i_start = 1'b0;
    wait_done("zero");
    chk("zero_edges", edges.size(), 68);
    if (edges.size() > 0) chk("zero_env_len", edges[edges.size()-1] - edges[0], 1050);

    // All-one word.
    edges.delete();
    start_frame(32'hFFFF_FFFF);
    wait_done("ones");
    chk("ones_edges", edges.size(), 68);
    if (edges.size() > 0) chk("ones_env_len", edges[edges.size()-1] - edges[0], 1754);

    // Back-to-back: start presented in the done cycle.
    start_frame(32'hA5A5_0F0F);
    wait_done("b2b_first");
    edges.delete();
    bus.i_start = 1'b1;
    bus.i_data  = 32'h00FF_A25D;
    @(negedge clk);
    bus.i_start = 1'b0;
    #1;
    chk("b2b_busy", bus.o_busy,   1);
    chk("b2b_env",  bus.o_ir_env, 1);
    chk("b2b_gap",  busy_rise - done_cyc, 1);
    wait_done("b2b_second");
    check_frame(32'h00FF_A25D, "b2b");

    // Reset asserted during the space of bit 10.
    edges.delete();
    start_frame(32'h0000_0000);
    repeat (525) @(negedge clk);
    chk("pre_rst_busy", bus.o_busy,   1);
    chk("pre_rst_env",  bus.o_ir_env, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", bus.o_busy,   0);
    chk("mid_rst_env",  bus.o_ir_env, 0);
    chk("mid_rst_tx",   bus.o_ir_tx,  0);
    chk("mid_rst_done", bus.o_done,   0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    edges.delete();
    start_frame(32'h00FF_A25D);
    wait_done("post_rst");
    check_frame(32'h00FF_A25D, "post_rst");

    @(negedge clk);
    chk("carrier_errors", car_err, 0);
    chk("carrier_samples", car_n > 1000, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ir_tx.md
# ir_tx

NEC-format infrared transmitter, the send-side counterpart of the team's IR receiver. It accepts a 32-bit custom/data word and emits a timed frame on a 38 kHz-modulated LED drive output. The frame is a leader, 32 pulse-distance bits sent MSB first, a stop mark, and a gap that pads the frame to a fixed period. It sits between control logic (key scanner or CPU register) and the IR LED driver pin. It also drives an unmodulated envelope output for loopback into the receiver.

## Interface
- `TICK_DIV`, default 50: clk cycles per 1 µs timing tick (50 MHz clk).
- `CARRIER_DIV`, default 1316: clk cycles per carrier period (about 38 kHz). The high half is `CARRIER_DIV/2`.
- `clk` in 1: system clock, 50 MHz.
- `rst_n` in 1: reset, asynchronous, active-low.
- `i_start` in 1: start request, sampled only while `o_busy`=0.
- `i_data` in 32: frame word, latched on an accepted start.
- `i_repeat` in 1: request a repeat code (see Configuration).
- `o_ir_tx` out 1: modulated LED drive, high = LED on.
- `o_ir_env` out 1: envelope, high = mark.
- `o_busy` out 1: high while a frame or repeat is in progress.
- `o_done` out 1: one-cycle pulse at the end of each frame or repeat.

## Operation
- All durations below are in µs ticks.
- **Tick counter**
  - Divides clk by `TICK_DIV`.
  - Cleared on an accepted start, so frame timing is phase-exact.
- **Start**
  - `i_start`=1 with `o_busy`=0 latches `i_data` into the shift register and enters LEAD_MARK.
  - `i_start` while busy is ignored, with no queuing.
- **States**
  - IDLE: envelope 0.
  - LEAD_MARK: 9000 mark.
  - LEAD_SPACE: 4500 space.
  - BIT_MARK: 560 mark.
  - BIT_SPACE: 560 space for a 0, 1690 for a 1.
  - STOP_MARK: 560 mark.
  - GAP: space until 108000 after the leader started.
- **Bit sequencing**
  - Bit k (k = 0..31) carries `i_data[31-k]`.
  - The 6-bit bit counter advances at the end of each BIT_SPACE.
  - After the 32nd bit, go to STOP_MARK.
- **Counters**
  - Duration counter: 17 bits, reloaded at every state entry.
  - Frame counter: 17 bits, counts ticks from leader start and saturates at 108000.
- **GAP exit**
  - Pulse `o_done`, drop `o_busy`, and return to IDLE.
  - With the macro enabled and `i_repeat`=1, go to REP_MARK instead.
- **Carrier and output**
  - The carrier counter restarts at each mark entry, so every mark begins with a high carrier half.
  - `o_ir_tx` = `o_ir_env` & carrier.
  - `o_ir_tx` is 0 during spaces and in IDLE.
- **Reset**
  - Async reset, including mid-frame: all outputs 0 and state IDLE immediately.
  - The latched word is discarded.

## Timing
- **Reset values:** `o_ir_tx`=0, `o_ir_env`=0, `o_busy`=0, `o_done`=0.
- **Start latency:**
  - `i_start` sampled at edge t.
  - `o_busy`, `o_ir_env` and `o_ir_tx` are all 1 from edge t+1.
- **Exactness:** each state lasts exactly N×`TICK_DIV` clk cycles, with N as listed in Operation.
- **Envelope length** (leader start to end of stop mark):
  - All-zero word: 9000 + 4500 + 32×1120 + 560 = 49900.
  - All-one word: 9000 + 4500 + 32×2250 + 560 = 86060.
- **Done:**
  - `o_done`=1 for exactly one cycle, 108000×`TICK_DIV` cycles after edge t+1.
  - `o_busy` reads 0 in that same cycle.
  - An `i_start` in the done cycle is accepted, giving back-to-back frames with no extra gap.
- **All outputs registered:** no combinational path from inputs to outputs.

## Configuration
- **`IR_TX_REPEAT_EN` defined:** adds states REP_MARK, REP_SPACE, REP_STOP and REP_GAP.
  - REP_MARK: 9000 mark.
  - REP_SPACE: 2250 space.
  - REP_STOP: 560 mark.
  - REP_GAP: pads to 108000 from REP_MARK entry.
  - `i_repeat` is sampled at the exit of GAP or REP_GAP. If 1, go to REP_MARK; otherwise go to IDLE.
  - `o_done` pulses at the end of every frame and every repeat.
  - `o_busy` stays 1 across chained repeats.
- **Not defined:** repeat states are absent, `i_repeat` is ignored, and GAP always returns to IDLE.

## Test plan
- **Basic frame:** reset, then start with `i_data`=32'h00FF_A25D.
  - Envelope is a 9000 mark and a 4500 space, then bits matching 0x00FFA25D MSB first with 560/1690 spaces, then a 560 stop mark.
  - `o_done` comes 5,400,000 cycles after `o_busy` rises.
- **Length extremes:** `i_data`=0 gives an envelope of 49900 µs; `i_data`=32'hFFFF_FFFF gives 86060 µs. The done time is identical in both cases.
- **Carrier:** during any mark, `o_ir_tx` has period 1316 cycles, is high for the first 658 cycles of each mark, and is 0 in all spaces.
- **Handshake:**
  - `i_start` pulses mid-frame with different data produce no change to the frame.
  - A start in the `o_done` cycle begins the next leader on the following edge.
- **Reset mid-frame:** assert `rst_n`=0 during BIT_SPACE of bit 10. All outputs go 0 asynchronously, and a fresh start afterwards sends a full frame.
- **Loopback and repeat:**
  - Feed `~o_ir_env` to the IR receiver's inverted input; its 32-bit output equals `i_data`.
  - With `IR_TX_REPEAT_EN` and `i_repeat`=1, a 9000/2250/560 repeat follows at 108000 µs intervals. Each repeat ends with an `o_done` pulse.
